axi_write_port_arbiter: RTL and testbench



---
 rtl/axi_write_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axi_write_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_port_arbiter.sv
// Round-robin arbiter that shares one write FIFO and request channel among
// several AXI slave write ports, one whole burst at a time.
module axi_write_port_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int FIFO_ADDR_WIDTH = 25,
    parameter int SZ_WIDTH        = 13
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_PORTS-1:0]                 req_write_req,
    input  logic [NUM_PORTS*FIFO_ADDR_WIDTH-1:0] req_write_addr,
    input  logic [NUM_PORTS*SZ_WIDTH-1:0]        req_write_byte_sz,
    input  logic [NUM_PORTS-1:0]                 req_fifo_push,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_PORTS-1:0]                 req_wlast_beat,
    output logic [NUM_PORTS-1:0]                 req_fifo_full,
    input  logic                                 fifo_full,
    output logic                                 fifo_push,
    output logic [DATA_WIDTH-1:0]                data_to_fifo,
    output logic                                 write_req,
    output logic [FIFO_ADDR_WIDTH-1:0]           write_addr,
    output logic [SZ_WIDTH-1:0]                  write_byte_sz,
    output logic [NUM_PORTS-1:0]                 grant,
    output logic [SZ_WIDTH-1:0]                  beat_cnt
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DATA
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [NUM_PORTS-1:0]       r_pending;
    logic [NUM_PORTS-1:0]       r_grant;
    logic [PW-1:0]              r_rr_ptr;
    logic [PW-1:0]              r_gidx;
    logic [PW-1:0]              w_sel_idx;
    logic                       w_sel_valid;
    int                         w_j;
    logic [FIFO_ADDR_WIDTH-1:0] r_addr_q [NUM_PORTS];
    logic [SZ_WIDTH-1:0]        r_sz_q   [NUM_PORTS];
    logic                       r_write_req;
    logic [FIFO_ADDR_WIDTH-1:0] r_write_addr;
    logic [SZ_WIDTH-1:0]        r_write_byte_sz;
    logic [SZ_WIDTH-1:0]        r_beat_cnt;
    logic                       w_in_data;
    logic                       w_glast;
    logic                       w_done;
    logic                       w_push;
    logic [DATA_WIDTH-1:0]      w_data;

    assign w_in_data = (r_state == S_DATA);
    assign w_glast   = |(req_wlast_beat & r_grant);
    assign w_done    = w_in_data & w_glast;
    assign w_push    = w_in_data & (|(req_fifo_push & r_grant)) & ~fifo_full;

    // First pending port at or after the round-robin pointer; the
    // descending scan lets the smallest offset win.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_j         = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_j = (int'(r_rr_ptr) + k) % NUM_PORTS;
            if (r_pending[w_j]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = PW'(w_j);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_sel_valid) w_next = S_ISSUE;
            S_ISSUE: w_next = S_DATA;
            S_DATA:  if (w_glast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A new request wins over the end-of-burst clear on the same port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_addr_q[i] <= '0;
                r_sz_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_write_req[i]) begin
                    r_pending[i] <= 1'b1;
                    r_addr_q[i]  <= req_write_addr[i*FIFO_ADDR_WIDTH +: FIFO_ADDR_WIDTH];
                    r_sz_q[i]    <= req_write_byte_sz[i*SZ_WIDTH +: SZ_WIDTH];
                end else if (w_done && r_grant[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_grant         <= '0;
            r_gidx          <= '0;
            r_rr_ptr        <= '0;
            r_write_req     <= 1'b0;
            r_write_addr    <= '0;
            r_write_byte_sz <= '0;
        end else begin
            r_write_req <= (r_state == S_IDLE) && w_sel_valid;
            if ((r_state == S_IDLE) && w_sel_valid) begin
                r_grant         <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_sel_idx;
                r_gidx          <= w_sel_idx;
                r_write_addr    <= r_addr_q[w_sel_idx];
                r_write_byte_sz <= r_sz_q[w_sel_idx];
            end
            if (r_state == S_ISSUE) begin
                r_rr_ptr <= (r_gidx == PW'(NUM_PORTS - 1)) ? '0 : r_gidx + PW'(1);
            end
            if (w_done) begin
                r_grant <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_beat_cnt <= '0;
        end else if (w_push && (r_beat_cnt != '1)) begin
            r_beat_cnt <= r_beat_cnt + SZ_WIDTH'(1);
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_push     = w_push;
    assign data_to_fifo  = w_data;
    assign req_fifo_full = {NUM_PORTS{fifo_full}} | ~({NUM_PORTS{w_in_data}} & r_grant);
    assign write_req     = r_write_req;
    assign write_addr    = r_write_addr;
    assign write_byte_sz = r_write_byte_sz;
    assign grant         = r_grant;
    assign beat_cnt      = r_beat_cnt;

endmodule

// File: tb/tb_axi_write_port_arbiter.sv
// Randomized bench for axi_write_port_arbiter with a round-robin reference
// model; three ports so pointer wrap-around is exercised.
module tb_axi_write_port_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int AW = 25;
    localparam int SW = 13;

    logic              clock;
    logic              reset_n;
    logic [N-1:0]      req_write_req;
    logic [N*AW-1:0]   req_write_addr;
    logic [N*SW-1:0]   req_write_byte_sz;
    logic [N-1:0]      req_fifo_push;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_wlast_beat;
    logic [N-1:0]      req_fifo_full;
    logic              fifo_full;
    logic              fifo_push;
    logic [DW-1:0]     data_to_fifo;
    logic              write_req;
    logic [AW-1:0]     write_addr;
    logic [SW-1:0]     write_byte_sz;
    logic [N-1:0]      grant;
    logic [SW-1:0]     beat_cnt;

    axi_write_port_arbiter #(
        .NUM_PORTS(N), .DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW), .SZ_WIDTH(SW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_write_req(req_write_req), .req_write_addr(req_write_addr),
        .req_write_byte_sz(req_write_byte_sz), .req_fifo_push(req_fifo_push),
        .req_data(req_data), .req_wlast_beat(req_wlast_beat),
        .req_fifo_full(req_fifo_full), .fifo_full(fifo_full),
        .fifo_push(fifo_push), .data_to_fifo(data_to_fifo),
        .write_req(write_req), .write_addr(write_addr),
        .write_byte_sz(write_byte_sz), .grant(grant), .beat_cnt(beat_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state: round-robin pointer and per-port latched request
    int          m_rr;
    logic [AW-1:0] m_addr [N];
    logic [SW-1:0] m_sz   [N];

    // Observations gathered while serving one burst
    bit          o_found;
    int          o_lat, o_push, o_dhit, o_bphit, o_cyc, o_intr, o_wrx;
    logic [N-1:0]  o_g, o_gafter;
    logic [AW-1:0] o_a;
    logic [SW-1:0] o_s, o_bc;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_inputs();
        req_write_req  = '0;
        req_fifo_push  = '0;
        req_wlast_beat = '0;
        fifo_full      = 1'b0;
    endtask

    // One-cycle request pulse on every port in mask; leaves us one cycle later.
    task automatic pulse(input logic [N-1:0] mask, input bit rnd);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (rnd) begin
                    m_addr[i] = AW'($urandom);
                    m_sz[i]   = SW'($urandom);
                end
                req_write_addr[i*AW +: AW]    = m_addr[i];
                req_write_byte_sz[i*SW +: SW] = m_sz[i];
            end
        end
        req_write_req = mask;
        step();
        req_write_req = '0;
    endtask

    // Behaves as slave p: waits for its burst, pushes beats as wready allows,
    // other ports optionally push garbage and stray wlast pulses.
    task automatic serve(input int p, input int beats, input bit toggle, input bit intrude);
        int bcount;
        int cyc;
        bit full;
        bit intr;
        logic [DW-1:0] d;
        logic [DW-1:0] owner_d;
        o_found = 0; o_lat = 0; o_push = 0; o_dhit = 0; o_bphit = 0;
        o_cyc = 0; o_intr = 0; o_wrx = 0;
        o_g = '0; o_a = '0; o_s = '0; o_bc = '0; o_gafter = '0;
        owner_d = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (write_req === 1'b1) begin
                o_found = 1; o_g = grant; o_a = write_addr; o_s = write_byte_sz;
                break;
            end
            step();
            o_lat++;
        end
        if (o_found) begin
            step();
            bcount = 0;
            cyc = 0;
            while (bcount < beats && cyc < 200) begin
                full = toggle && (cyc % 2 == 1);
                fifo_full = full;
                req_fifo_push = '0;
                req_wlast_beat = '0;
                for (int q = 0; q < N; q++) begin
                    d = {$urandom, $urandom};
                    req_data[q*DW +: DW] = d;
                    if (q == p) begin
                        owner_d = d;
                        req_fifo_push[q] = !full;
                        req_wlast_beat[q] = !full && (bcount == beats - 1);
                    end else if (intrude) begin
                        req_fifo_push[q] = 1'b1;
                        req_wlast_beat[q] = 1'($urandom);
                    end
                end
                @(negedge clock);
                if (fifo_push === 1'b1) o_push++;
                if (fifo_push === 1'b1 && data_to_fifo === owner_d) o_dhit++;
                if (req_fifo_full[p] === full) o_bphit++;
                intr = (data_to_fifo === owner_d);
                for (int q = 0; q < N; q++) begin
                    if (q != p && req_fifo_full[q] !== 1'b1) intr = 0;
                end
                if (intr) o_intr++;
                if (write_req !== 1'b0) o_wrx++;
                o_cyc++;
                if (!full) bcount++;
                step();
                cyc++;
            end
            clear_inputs();
            @(negedge clock);
            o_gafter = grant;
            o_bc = beat_cnt;
            step();
            m_rr = (p + 1) % N;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        req_fifo_push = '1;
        req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_write_addr = '0;
        req_write_byte_sz = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (grant !== '0) begin bad++; $display("FAIL rst_grant got=%0h want=0", grant); end
        total++; if (write_req !== 1'b0) begin bad++; $display("FAIL rst_write_req got=%0b want=0", write_req); end
        total++; if (write_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0h want=0", write_addr); end
        total++; if (write_byte_sz !== '0) begin bad++; $display("FAIL rst_sz got=%0h want=0", write_byte_sz); end
        total++; if (beat_cnt !== '0) begin bad++; $display("FAIL rst_beat_cnt got=%0d want=0", beat_cnt); end
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL rst_fifo_push got=%0b want=0", fifo_push); end
        total++; if (data_to_fifo !== '0) begin bad++; $display("FAIL rst_data got=%0h want=0", data_to_fifo); end
        total++; if (req_fifo_full !== '1) begin bad++; $display("FAIL rst_req_full got=%0b want=111", req_fifo_full); end
        @(posedge clock);
        #1;
        clear_inputs();
        reset_n = 1'b1;
        m_rr = 0;
        step();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] masks [5];
        int order [$];
        logic [N-1:0] pend;
        logic [N-1:0] mask;
        int p, beats, n;
        masks[0] = 3'b011; masks[1] = 3'b001; masks[2] = 3'b011;
        masks[3] = 3'b010; masks[4] = 3'b111;
        for (int r = 0; r < 11; r++) begin
            mask = (r < 5) ? masks[r] : N'($urandom_range(1, (1 << N) - 1));
            pend = mask;
            order.delete();
            pulse(mask, 1);
            n = 0;
            while (pend != '0) begin
                p = model_pick(pend);
                beats = $urandom_range(1, 5);
                serve(p, beats, 0, 1);
                total++; if (!o_found) begin bad++; $display("FAIL rr_found r=%0d got=0 want=1", r); end
                total++;
                if (o_lat !== (n == 0 ? 1 : 0)) begin
                    bad++; $display("FAIL rr_latency r=%0d got=%0d want=%0d", r, o_lat, (n == 0 ? 1 : 0));
                end
                total++;
                if (o_g !== N'(1 << p)) begin bad++; $display("FAIL rr_grant r=%0d got=%0b want=%0b", r, o_g, N'(1 << p)); end
                total++;
                if (o_a !== m_addr[p] || o_s !== m_sz[p]) begin
                    bad++; $display("FAIL rr_addr_sz r=%0d got=%0h/%0h want=%0h/%0h", r, o_a, o_s, m_addr[p], m_sz[p]);
                end
                total++;
                if (o_push !== beats || o_dhit !== beats) begin
                    bad++; $display("FAIL rr_pushes r=%0d got=%0d/%0d want=%0d", r, o_push, o_dhit, beats);
                end
                total++;
                if (o_gafter !== '0) begin bad++; $display("FAIL rr_release r=%0d got=%0b want=0", r, o_gafter); end
                order.push_back(oh2i(o_g));
                pend[p] = 1'b0;
                n++;
                if (!o_found) pend = '0;
            end
            if (r == 0) begin
                total++;
                if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
                    bad++; $display("FAIL rr_first_pair got=%p want=0,1", order);
                end
            end
            if (r == 2) begin
                total++;
                if (order.size() != 2 || order[0] != 1 || order[1] != 0) begin
                    bad++; $display("FAIL rr_second_pair got=%p want=1,0", order);
                end
            end
            if (r == 4) begin
                total++;
                if (order.size() != 3 || order[0] != 2 || order[1] != 0 || order[2] != 1) begin
                    bad++; $display("FAIL rr_wrap got=%p want=2,0,1", order);
                end
            end
        end
    endtask

    task automatic test_single();
        m_addr[0] = AW'(32'h100);
        m_sz[0]   = SW'(64);
        pulse(3'b001, 0);
        serve(0, 8, 0, 0);
        total++; if (!o_found) begin bad++; $display("FAIL single_found got=0 want=1"); end
        total++; if (o_lat !== 1) begin bad++; $display("FAIL single_latency got=%0d want=1", o_lat); end
        total++; if (o_g !== 3'b001) begin bad++; $display("FAIL single_grant got=%0b want=001", o_g); end
        total++; if (o_a !== AW'(32'h100)) begin bad++; $display("FAIL single_addr got=%0h want=100", o_a); end
        total++; if (o_s !== SW'(64)) begin bad++; $display("FAIL single_sz got=%0d want=64", o_s); end
        total++; if (o_push !== 8 || o_dhit !== 8) begin bad++; $display("FAIL single_pushes got=%0d/%0d want=8", o_push, o_dhit); end
        total++; if (o_bc !== SW'(8)) begin bad++; $display("FAIL single_beat_cnt got=%0d want=8", o_bc); end
        total++; if (o_gafter !== '0) begin bad++; $display("FAIL single_release got=%0b want=0", o_gafter); end
        total++; if (o_wrx !== 0) begin bad++; $display("FAIL single_write_req_once got=%0d want=0 extra", o_wrx); end
    endtask

    task automatic test_intruder();
        pulse(3'b001, 1);
        serve(0, 6, 0, 1);
        total++; if (!o_found) begin bad++; $display("FAIL intr_found got=0 want=1"); end
        total++; if (o_intr !== o_cyc) begin bad++; $display("FAIL intr_blocked got=%0d want=%0d", o_intr, o_cyc); end
        total++; if (o_push !== 6 || o_dhit !== 6) begin bad++; $display("FAIL intr_pushes got=%0d/%0d want=6", o_push, o_dhit); end
    endtask

    task automatic test_full_toggle();
        int p;
        p = $urandom_range(0, N - 1);
        pulse(N'(1 << p), 1);
        serve(p, 4, 1, 0);
        total++; if (!o_found) begin bad++; $display("FAIL full_found got=0 want=1"); end
        total++; if (o_push !== 4 || o_dhit !== 4) begin bad++; $display("FAIL full_pushes got=%0d/%0d want=4", o_push, o_dhit); end
        total++; if (o_bphit !== o_cyc) begin bad++; $display("FAIL full_track got=%0d want=%0d", o_bphit, o_cyc); end
        total++; if (o_bc !== SW'(4)) begin bad++; $display("FAIL full_beat_cnt got=%0d want=4", o_bc); end
    endtask

    task automatic test_reset_mid();
        bit found;
        logic [N-1:0] gacc;
        found = 0;
        pulse(3'b001, 1);
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            if (write_req === 1'b1) found = 1;
            step();
        end
        total++; if (!found) begin bad++; $display("FAIL rmid_found got=0 want=1"); end
        for (int b = 1; b <= 3; b++) begin
            req_fifo_push = 3'b001;
            req_data[DW-1:0] = {$urandom, $urandom};
            if (b == 3) reset_n = 1'b0;
            @(negedge clock);
            if (b < 3) step();
        end
        total++; if (grant !== '0) begin bad++; $display("FAIL rmid_grant got=%0b want=0", grant); end
        total++; if (write_req !== 1'b0) begin bad++; $display("FAIL rmid_write_req got=%0b want=0", write_req); end
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL rmid_fifo_push got=%0b want=0", fifo_push); end
        total++; if (req_fifo_full !== '1) begin bad++; $display("FAIL rmid_req_full got=%0b want=111", req_fifo_full); end
        total++; if (beat_cnt !== '0) begin bad++; $display("FAIL rmid_beat_cnt got=%0d want=0", beat_cnt); end
        step();
        clear_inputs();
        step();
        reset_n = 1'b1;
        m_rr = 0;
        gacc = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            gacc = gacc | grant;
            step();
        end
        total++; if (gacc !== '0) begin bad++; $display("FAIL rmid_pending_cleared got=%0b want=0", gacc); end
        pulse(3'b001, 1);
        serve(0, 3, 0, 0);
        total++; if (!o_found || o_lat !== 1) begin bad++; $display("FAIL rmid_restart got=%0d/%0d want=1/1", o_found, o_lat); end
        total++;
        if (o_g !== 3'b001 || o_a !== m_addr[0] || o_push !== 3) begin
            bad++; $display("FAIL rmid_serve got=%0b/%0h/%0d want=001/%0h/3", o_g, o_a, o_push, m_addr[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_intruder();
        test_full_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
